quizbus_arbiter: RTL
====================

// Module: quizbus_arbiter
// PURPOSE
//   Shares one quizif-style strobe bus (as/rw/ds/da, 8-bit addr) among N local requesters.
//   Round-robin arbiter plus bus-sequencing FSM. Sits on the RD (bus-master) side of the bus.
//   Runs the address phase, then the data phase with a 4-phase ds/da handshake.
//   Returns read data and completion status to the granted requester.
// PARAMETERS
//   N            4    number of requesters (2..8)
//   AW           8    address width
//   DW           8    data width
//   TIMEOUT_CYC  16   data-phase watchdog limit in cycles (used only with QUIZBUS_TIMEOUT_EN)
// PORTS
//   clk        in   1      bus clock; all logic on rising edge
//   rst        in   1      asynchronous, active-low reset
//   req        in   N      per-requester request; held until its done pulse
//   req_rw     in   N      per-requester direction: 1=read, 0=write
//   req_addr   in   N*AW   per-requester address, flattened; slice i = [i*AW +: AW]
//   req_wdata  in   N*DW   per-requester write data, flattened
//   gnt        out  N      one-hot grant; held from ADDR through RESP
//   done       out  N      one-hot, 1-cycle completion pulse
//   rdata      out  DW     read data; valid while done is high
//   err        out  1      completion was a timeout abort; valid with done
//   bus_addr   out  AW     bus address
//   bus_as     out  1      address strobe
//   bus_rw     out  1      bus direction
//   bus_ds     out  1      data strobe
//   bus_wdata  out  DW     bus write data
//   bus_da     in   1      data acknowledge from bus manager
//   bus_rdata  in   DW     bus read data; sampled when da=1
// BEHAVIOUR
//   - Reset (rst=0, async): state IDLE. All outputs 0. RR pointer = N-1, so requester 0 has
//     first priority.
//   - All outputs are registered.
//   - FSM IDLE: if |req, select first requester at or after pointer+1 (wrapping).
//     Latch its idx/addr/rw/wdata, set gnt[idx], go ADDR. Pointer <= idx.
//   - FSM ADDR (1 cycle): bus_as=1; bus_addr/bus_rw/bus_wdata = latched values. Go DATA.
//   - FSM DATA: bus_as=1, bus_ds=1. Stay until bus_da=1 is sampled.
//     On that edge: capture bus_rdata (reads only; writes give rdata=0), drop as/ds,
//     pulse done[idx], go RESP.
//   - FSM RESP: hold gnt. Wait for bus_da=0, then clear gnt and go IDLE.
//     RESP completes the 4-phase handshake; no new as is issued while da is high.
//   - Latency: req sampled at edge 0 gives as at edge 1 and ds at edge 2.
//     If da=1 is sampled at edge 3, done is high in the cycle after edge 3 (3 cycles minimum).
//   - req_* of non-granted requesters are ignored. Changes to the granted requester's
//     req_* after latch are ignored.
//   - A requester still holding req after done is re-arbitrated normally.
//     The pointer has moved past it, so the others are served first.
//   - req dropping mid-transaction does not abort the bus cycle; done still pulses.
//   - bus_da=1 while in IDLE or ADDR is ignored.
//   - Reset mid-transaction: bus released immediately (as=ds=0). No done pulse.
// CONFIGURATION
//   QUIZBUS_TIMEOUT_EN defined:
//     - Counter runs in DATA. When bus_da stays 0 for TIMEOUT_CYC cycles:
//       drop as/ds, pulse done[idx] with err=1 and rdata=0, go RESP.
//     - Counter clears on entry to DATA.
//   QUIZBUS_TIMEOUT_EN undefined:
//     - No counter. DATA waits indefinitely. err is tied 0.
// STRUCTURE
//   - quizbus_pkg:
//     - typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} qb_state_e
//     - localparam default widths
//     - function to extract a requester slice from the flattened buses
//   - Sub-module quizbus_rr_pick: combinational round-robin.
//     In: req[N], pointer. Out: one-hot pick, idx, valid.
// TESTING
//   - Reset: rst=0 mid-DATA -> as=ds=0, gnt=0, done=0 within the same cycle; IDLE after release.
//   - Single read: req[2], addr=8'h3C, rw=1; manager returns da=1 two cycles after ds with
//     rdata=8'hA5 -> as for 1 cycle, then ds; done[2] with rdata=8'hA5, err=0.
//   - Round robin: req=4'b1111 held continuously -> grant order 0,1,2,3,0.
//     No as issued while da is still high.
//   - Write: req[1], rw=0, addr=8'h10, wdata=8'h5A -> bus_wdata=8'h5A through DATA;
//     done[1] with rdata=8'h00.
//   - Timeout (macro on, TIMEOUT_CYC=16): da never asserted -> ds drops after 16 DATA cycles;
//     done with err=1. Macro off: ds stays high and no done.

Source files
------------

// File: rtl/quizbus_pkg.sv
// ---------------------------------------------------------------------------
// quizbus_pkg
//   Shared types, default widths and a slice helper for the quizbus
//   arbiter slice of the codebase.
//   Contents:
//     qb_state_e  - bus-sequencing FSM states
//     QB_*        - default parameter values
//     qb_slice()  - pulls one requester's field out of a flattened bus
//   Optional feature macro used by the arbiter: QUIZBUS_TIMEOUT_EN
// ---------------------------------------------------------------------------
package quizbus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } qb_state_e;

    localparam int QB_N           = 4;
    localparam int QB_AW          = 8;
    localparam int QB_DW          = 8;
    localparam int QB_TIMEOUT_CYC = 16;

    // Flattened requester buses are widened to QB_FLAT_W before slicing, so
    // N*AW and N*DW must not exceed it; a slice is at most QB_SLICE_W bits.
    localparam int QB_FLAT_W  = 256;
    localparam int QB_SLICE_W = 64;

    // Returns field 'idx' of a bus built from fields 'width' bits wide,
    // right-aligned; the caller truncates to the real field width.
    function automatic logic [QB_SLICE_W-1:0] qb_slice(
        input logic [QB_FLAT_W-1:0] flat,
        input int unsigned          idx,
        input int unsigned          width
    );
        logic [QB_FLAT_W-1:0] shifted;
        shifted = flat >> (idx * width);
        return shifted[QB_SLICE_W-1:0];
    endfunction

endpackage

// File: rtl/quizbus_rr_pick.sv
// ---------------------------------------------------------------------------
// quizbus_rr_pick
//   Combinational round-robin selector. Searches for the first active
//   request strictly after the pointer, wrapping, so the pointer's own
//   requester has the lowest priority.
//   Ports:
//     i_req   [N]   active requests
//     i_ptr   [IW]  index of the most recently granted requester
//     o_pick  [N]   one-hot winner (all zero when no request)
//     o_idx   [IW]  binary index of the winner
//     o_valid       at least one request is active
// ---------------------------------------------------------------------------
module quizbus_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_pick,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    int w_cand;

    always_comb begin
        // NOTE: every output gets a default before the search loop so no
        // path through the block leaves a value held, which would infer a latch.
        o_pick  = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = 0;
        for (int k = 1; k <= N; k++) begin
            w_cand = (int'(i_ptr) + k) % N;
            if (!o_valid && i_req[w_cand]) begin
                o_valid        = 1'b1;
                o_idx          = IW'(w_cand);
                o_pick[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/quizbus_arbiter.sv
// ---------------------------------------------------------------------------
// quizbus_arbiter
//   Bus-master side of a quizif strobe bus shared by N local requesters.
//   A round-robin pick chooses one requester; the FSM then runs the address
//   phase (as), the data phase (as+ds until da) and waits for da to fall so
//   the 4-phase ds/da handshake completes before the next address phase.
//   Every output is a register.
//   Optional feature: define QUIZBUS_TIMEOUT_EN to abort a data phase that
//   sees no da within TIMEOUT_CYC cycles (completion then reports err=1).
//   Ports:
//     clk, rst                  clock, asynchronous active-low reset
//     req/req_rw [N]            request and direction (1=read) per requester
//     req_addr  [N*AW]          flattened addresses, slice i = [i*AW +: AW]
//     req_wdata [N*DW]          flattened write data
//     gnt  [N]                  one-hot grant, ADDR through RESP
//     done [N]                  one-hot single-cycle completion pulse
//     rdata [DW], err           read data / timeout flag, valid with done
//     bus_addr/as/rw/ds/wdata   bus outputs
//     bus_da, bus_rdata         bus inputs from the manager
// ---------------------------------------------------------------------------
module quizbus_arbiter
    import quizbus_pkg::*;
#(
    parameter int N           = QB_N,
    parameter int AW          = QB_AW,
    parameter int DW          = QB_DW,
    parameter int TIMEOUT_CYC = QB_TIMEOUT_CYC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    req_rw,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*DW-1:0] req_wdata,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    done,
    output logic [DW-1:0]   rdata,
    output logic            err,
    output logic [AW-1:0]   bus_addr,
    output logic            bus_as,
    output logic            bus_rw,
    output logic            bus_ds,
    output logic [DW-1:0]   bus_wdata,
    input  logic            bus_da,
    input  logic [DW-1:0]   bus_rdata
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    qb_state_e     r_state;
    logic [IW-1:0] r_ptr;
    logic [AW-1:0] r_addr;
    logic          r_rw;
    logic [DW-1:0] r_wdata;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  r_done;
    logic [DW-1:0] r_rdata;
    logic [AW-1:0] r_bus_addr;
    logic          r_bus_as;
    logic          r_bus_rw;
    logic          r_bus_ds;
    logic [DW-1:0] r_bus_wdata;

    logic [N-1:0]  w_pick;
    logic [IW-1:0] w_idx;
    logic          w_valid;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    quizbus_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_idx   (w_idx),
        .o_valid (w_valid)
    );

    assign w_sel_addr  = AW'(qb_slice(QB_FLAT_W'(req_addr),  32'(w_idx), AW));
    assign w_sel_wdata = DW'(qb_slice(QB_FLAT_W'(req_wdata), 32'(w_idx), DW));

`ifdef QUIZBUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_tmo_cnt;
    logic          r_err;
    logic          w_tmo_hit;

    // Counts DATA cycles without an accepted da; fires on the last allowed one.
    assign w_tmo_hit = (r_tmo_cnt == TW'(TIMEOUT_CYC - 1));
    assign err       = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_ptr       <= IW'(N - 1);
            r_addr      <= '0;
            r_rw        <= 1'b0;
            r_wdata     <= '0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_rdata     <= '0;
            r_bus_addr  <= '0;
            r_bus_as    <= 1'b0;
            r_bus_rw    <= 1'b0;
            r_bus_ds    <= 1'b0;
            r_bus_wdata <= '0;
`ifdef QUIZBUS_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            // NOTE: state and registered outputs use non-blocking assignments
            // so every branch sees the pre-edge values, matching the flops.
            case (r_state)
                IDLE: begin
                    r_done <= '0;
                    if (w_valid) begin
                        r_gnt   <= w_pick;
                        r_ptr   <= w_idx;
                        r_addr  <= w_sel_addr;
                        r_rw    <= req_rw[w_idx];
                        r_wdata <= w_sel_wdata;
                        r_state <= ADDR;
                    end
                end
                ADDR: begin
                    r_bus_as    <= 1'b1;
                    r_bus_addr  <= r_addr;
                    r_bus_rw    <= r_rw;
                    r_bus_wdata <= r_wdata;
`ifdef QUIZBUS_TIMEOUT_EN
                    r_tmo_cnt   <= '0;
`endif
                    r_state     <= DATA;
                end
                DATA: begin
                    // da only counts once ds is on the bus; an early da is ignored.
                    if (r_bus_ds && bus_da) begin
                        r_bus_as <= 1'b0;
                        r_bus_ds <= 1'b0;
                        r_done   <= r_gnt;
                        r_rdata  <= r_rw ? bus_rdata : '0;
                        r_state  <= RESP;
`ifdef QUIZBUS_TIMEOUT_EN
                    end else if (w_tmo_hit) begin
                        r_bus_as <= 1'b0;
                        r_bus_ds <= 1'b0;
                        r_done   <= r_gnt;
                        r_rdata  <= '0;
                        r_err    <= 1'b1;
                        r_state  <= RESP;
`endif
                    end else begin
                        r_bus_ds  <= 1'b1;
`ifdef QUIZBUS_TIMEOUT_EN
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    r_done  <= '0;
                    r_rdata <= '0;
`ifdef QUIZBUS_TIMEOUT_EN
                    r_err   <= 1'b0;
`endif
                    // Hold the grant until the manager releases da.
                    if (!bus_da) begin
                        r_gnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign rdata     = r_rdata;
    assign bus_addr  = r_bus_addr;
    assign bus_as    = r_bus_as;
    assign bus_rw    = r_bus_rw;
    assign bus_ds    = r_bus_ds;
    assign bus_wdata = r_bus_wdata;

endmodule
